hilbert_scheduler: RTL

- Time-shares one Hilbert transformer engine between NUM_CH interferometer channels sampled on a common tick.
- Captures all channel samples on tick_i and issues them to the engine one at a time, with the channel index selecting the engine's per-channel delay-line bank.
- Collects each 90-degree-shifted result and publishes all results together with a one-cycle valid strobe.
- Detects ticks arriving while busy (overrun) and engine stalls (timeout).

---
 rtl/hilbert_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hilbert_scheduler.sv
// Time-shares a single Hilbert transformer engine across NUM_CH channels captured on a common tick.
// Each channel is issued in turn, its shifted result collected, and all results published together.
module hilbert_scheduler #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 64,
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    tick_i,
    input  logic [NUM_CH*WIDTH-1:0] signal_i,
    output logic                    eng_tick_o,
    output logic [CW-1:0]           eng_ch_o,
    output logic [WIDTH-1:0]        eng_signal_o,
    input  logic [WIDTH-1:0]        eng_signal_i,
    input  logic                    eng_done_i,
    output logic [NUM_CH*WIDTH-1:0] signal_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    overrun_o,
    output logic [15:0]             overrun_cnt_o,
    input  logic                    clear_i
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             ch_q, ch_d;
    logic [CW-1:0]             ch_inc;
    logic [TW-1:0]             timer_q, timer_d;
    logic [WIDTH-1:0]          sample_q [NUM_CH];
    logic [WIDTH-1:0]          sample_d [NUM_CH];
    logic [WIDTH-1:0]          result_q [NUM_CH];
    logic [WIDTH-1:0]          result_d [NUM_CH];
    logic [WIDTH-1:0]          sig_in   [NUM_CH];
    logic [NUM_CH*WIDTH-1:0]   out_q, out_d;
    logic                      valid_q, valid_d;
    logic                      eng_tick_q, eng_tick_d;
    logic [CW-1:0]             eng_ch_q, eng_ch_d;
    logic [WIDTH-1:0]          eng_sig_q, eng_sig_d;
    logic                      timeout_q, timeout_d;
    logic                      overrun_q, overrun_d;
    logic [15:0]               ocnt_q, ocnt_d;
    logic                      slot_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign sig_in[gi] = signal_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign ch_inc = ch_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        timer_d    = timer_q;
        sample_d   = sample_q;
        result_d   = result_q;
        out_d      = out_q;
        valid_d    = 1'b0;
        eng_tick_d = 1'b0;
        eng_ch_d   = eng_ch_q;
        eng_sig_d  = eng_sig_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        ocnt_d     = ocnt_q;
        slot_done  = 1'b0;

        // Clear first so that an event in the same cycle overrides it below.
        if (clear_i) begin
            timeout_d = 1'b0;
            overrun_d = 1'b0;
            ocnt_d    = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_i) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        sample_d[c] = sig_in[c];
                    end
                    ch_d       = '0;
                    state_d    = ST_ISSUE;
                    eng_tick_d = 1'b1;
                    eng_ch_d   = '0;
                    eng_sig_d  = sig_in[0];
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (eng_done_i) begin
                    result_d[ch_q] = eng_signal_i;
                    slot_done      = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    result_d[ch_q] = '0;
                    timeout_d      = 1'b1;
                    slot_done      = 1'b1;
                end
                if (slot_done) begin
                    if (ch_q != LAST_CH) begin
                        ch_d       = ch_inc;
                        state_d    = ST_ISSUE;
                        eng_tick_d = 1'b1;
                        eng_ch_d   = ch_inc;
                        eng_sig_d  = sample_q[ch_inc];
                    end else begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            out_d[c*WIDTH +: WIDTH] = result_d[c];
                        end
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick while a sequence is in flight is dropped and only counted.
        if (tick_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
            if (clear_i) begin
                ocnt_d = 16'd1;
            end else if (ocnt_q != 16'hFFFF) begin
                ocnt_d = ocnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            timer_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sample_q[c] <= '0;
                result_q[c] <= '0;
            end
            out_q      <= '0;
            valid_q    <= 1'b0;
            eng_tick_q <= 1'b0;
            eng_ch_q   <= '0;
            eng_sig_q  <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ocnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            timer_q    <= timer_d;
            sample_q   <= sample_d;
            result_q   <= result_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            eng_tick_q <= eng_tick_d;
            eng_ch_q   <= eng_ch_d;
            eng_sig_q  <= eng_sig_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            ocnt_q     <= ocnt_d;
        end
    end

    assign eng_tick_o    = eng_tick_q;
    assign eng_ch_o      = eng_ch_q;
    assign eng_signal_o  = eng_sig_q;
    assign signal_o      = out_q;
    assign valid_o       = valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;
    assign overrun_cnt_o = ocnt_q;

endmodule
